// File: rtl/jt6295_adpcm_dec_if.sv
// Voice-slot handshake between the timing generator, the ADPCM decoder and the mixer.
// The master drives strobes and nibbles; the slave returns slot and decoded samples.
interface jt6295_adpcm_dec_if #(parameter int SW = 12);
  logic                 cen;
  logic                 sync;
  logic                 en;
  logic                 restart;
  logic [3:0]           nibble;
  logic [1:0]           slot;
  logic signed [SW-1:0] snd;
  logic [1:0]           snd_ch;
  logic                 snd_valid;

  modport master (output cen, sync, en, restart, nibble,
                  input  slot, snd, snd_ch, snd_valid);
  modport slave  (input  cen, sync, en, restart, nibble,
                  output slot, snd, snd_ch, snd_valid);
endinterface

// File: rtl/jt6295_adpcm_dec.sv
// Four-voice time-multiplexed OKI ADPCM decoder: one slot per cen, two-edge latency,
// with a same-slot bypass for back-to-back strobes realigned by sync.
module jt6295_adpcm_dec #(
  parameter int SW = 12
) (
  input logic               clk,
  input logic               rst,
  jt6295_adpcm_dec_if.slave bus
);

  logic signed [SW-1:0] sig_mem [4];
  logic [5:0]           idx_mem [4];
  logic [1:0]           slot_q;
  logic [1:0]           cur_slot;

  logic                 vld_p1;
  logic [1:0]           slot_p1;
  logic                 en_p1;
  logic                 sgn_p1;
  logic [2:0]           mag_p1;
  logic signed [SW-1:0] sig_p1;
  logic [5:0]           idx_p1;

  logic [10:0]          step;
  logic [12:0]          diff;
  logic signed [SW+1:0] sig_ext;
  logic signed [SW+1:0] sum;
  logic signed [SW-1:0] wr_sig;
  logic [5:0]           wr_idx;

  logic signed [SW-1:0] snd_q;
  logic [1:0]           snd_ch_q;
  logic                 snd_valid_q;

  function automatic logic [10:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  return 11'd16;   6'd1:  return 11'd17;   6'd2:  return 11'd19;   6'd3:  return 11'd21;
      6'd4:  return 11'd23;   6'd5:  return 11'd25;   6'd6:  return 11'd28;   6'd7:  return 11'd31;
      6'd8:  return 11'd34;   6'd9:  return 11'd37;   6'd10: return 11'd41;   6'd11: return 11'd45;
      6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;   6'd15: return 11'd66;
      6'd16: return 11'd73;   6'd17: return 11'd80;   6'd18: return 11'd88;   6'd19: return 11'd97;
      6'd20: return 11'd107;  6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
      6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;  6'd27: return 11'd209;
      6'd28: return 11'd230;  6'd29: return 11'd253;  6'd30: return 11'd279;  6'd31: return 11'd307;
      6'd32: return 11'd337;  6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
      6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;  6'd39: return 11'd658;
      6'd40: return 11'd724;  6'd41: return 11'd796;  6'd42: return 11'd876;  6'd43: return 11'd963;
      6'd44: return 11'd1060; 6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
      default: return 11'd1552;
    endcase
  endfunction

  // Two guard bits keep sig +/- diff (up to 2910) from wrapping before the clamp.
  function automatic logic signed [SW-1:0] sat_sig(input logic signed [SW+1:0] v);
    if (v > 14'sd2047)       return 12'sd2047;
    else if (v < -14'sd2048) return -12'sd2048;
    else                     return v[SW-1:0];
  endfunction

  function automatic logic [5:0] sat_idx(input logic [5:0] idx, input logic [2:0] mag);
    logic signed [7:0] t;
    t = $signed({2'b00, idx});
    if (mag[2]) t = t + $signed({4'b0000, mag[1:0], 1'b0}) + 8'sd2;
    else        t = t - 8'sd1;
    if (t < 8'sd0)       return 6'd0;
    else if (t > 8'sd48) return 6'd48;
    else                 return t[5:0];
  endfunction

  assign cur_slot = bus.sync ? 2'd0 : slot_q;

  always_comb begin
    step    = step_lut(idx_p1);
    diff    = {5'd0, step[10:3]}
            + (mag_p1[2] ? {2'd0, step}       : 13'd0)
            + (mag_p1[1] ? {3'd0, step[10:1]} : 13'd0)
            + (mag_p1[0] ? {4'd0, step[10:2]} : 13'd0);
    sig_ext = {{2{sig_p1[SW-1]}}, sig_p1};
    sum     = sgn_p1 ? sig_ext - $signed({1'b0, diff}) : sig_ext + $signed({1'b0, diff});
    wr_sig  = en_p1 ? sat_sig(sum) : '0;
    wr_idx  = en_p1 ? sat_idx(idx_p1, mag_p1) : 6'd0;
  end

  // Stage 1: latch the strobe's slot and controls, read predictor state (with bypass)
  always_ff @(posedge clk) begin
    if (bus.cen) begin
      slot_p1 <= cur_slot;
      en_p1   <= bus.en;
      sgn_p1  <= bus.nibble[3];
      mag_p1  <= bus.nibble[2:0];
      if (bus.restart) begin
        sig_p1 <= '0;
        idx_p1 <= 6'd0;
      end else if (vld_p1 && slot_p1 == cur_slot) begin
        sig_p1 <= wr_sig;
        idx_p1 <= wr_idx;
      end else begin
        sig_p1 <= sig_mem[cur_slot];
        idx_p1 <= idx_mem[cur_slot];
      end
    end
  end

  // Stage 2: write back the decoded predictor state and publish the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= 2'd0;
      vld_p1      <= 1'b0;
      snd_valid_q <= 1'b0;
      snd_q       <= '0;
      snd_ch_q    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        sig_mem[i] <= '0;
        idx_mem[i] <= 6'd0;
      end
    end else begin
      vld_p1      <= bus.cen;
      snd_valid_q <= vld_p1;
      if (bus.cen) slot_q <= cur_slot + 2'd1;
      if (vld_p1) begin
        sig_mem[slot_p1] <= wr_sig;
        idx_mem[slot_p1] <= wr_idx;
        snd_q            <= wr_sig;
        snd_ch_q         <= slot_p1;
      end
    end
  end

  assign bus.slot      = slot_q;
  assign bus.snd       = snd_q;
  assign bus.snd_ch    = snd_ch_q;
  assign bus.snd_valid = snd_valid_q;

endmodule

// File: tb/tb_jt6295_adpcm_dec.sv
// Directed bench for the four-voice ADPCM decoder with hand-computed sample values.
module tb_jt6295_adpcm_dec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt6295_adpcm_dec_if #(.SW(12)) bus();
  jt6295_adpcm_dec #(.SW(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic signed [11:0] s; logic [1:0] ch; } ev_t;
  ev_t evq[$];
  ev_t mon_e;

  always @(posedge clk) begin
    #1;
    if (bus.snd_valid === 1'b1) begin
      mon_e.s  = bus.snd;
      mon_e.ch = bus.snd_ch;
      evq.push_back(mon_e);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic drive(input bit s, input bit e, input bit r, input logic [3:0] n);
    @(negedge clk);
    bus.cen = 1'b1; bus.sync = s; bus.en = e; bus.restart = r; bus.nibble = n;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cen = 1'b0; bus.sync = 1'b0; bus.en = 1'b0; bus.restart = 1'b0; bus.nibble = 4'h0;
  endtask

  task automatic get_ev(output logic signed [11:0] s, output logic [1:0] ch, output bit ok);
    ev_t e;
    ok = 1'b0; s = '0; ch = '0;
    for (int i = 0; i < 20; i++) begin
      if (evq.size() > 0) break;
      @(negedge clk);
    end
    if (evq.size() > 0) begin
      e = evq.pop_front();
      s = e.s; ch = e.ch; ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cen = 1'b0; bus.sync = 1'b0; bus.en = 1'b0; bus.restart = 1'b0; bus.nibble = 4'h0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL reset_slot: got %0d want 0", bus.slot); end
    n_vec++; if (bus.snd !== 12'sd0) begin n_err++; $display("FAIL reset_snd: got %0d want 0", bus.snd); end
    n_vec++; if (bus.snd_ch !== 2'd0) begin n_err++; $display("FAIL reset_snd_ch: got %0d want 0", bus.snd_ch); end
    n_vec++; if (bus.snd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.snd_valid); end
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic test_basic();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    logic signed [11:0] es [4] = '{12'sd93, -12'sd43, -12'sd24, 12'sd0};
    @(negedge clk);
    bus.cen = 1'b1; bus.sync = 1'b1; bus.en = 1'b1; bus.restart = 1'b1; bus.nibble = 4'h7;
    @(negedge clk);
    bus.cen = 1'b0; bus.sync = 1'b0; bus.restart = 1'b0;
    n_vec++; if (bus.snd_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: valid=%0b want 0", bus.snd_valid); end
    n_vec++; if (bus.slot !== 2'd1) begin n_err++; $display("FAIL sync_slot: got %0d want 1", bus.slot); end
    @(negedge clk);
    n_vec++; if (bus.snd_valid !== 1'b1 || bus.snd !== 12'sd30 || bus.snd_ch !== 2'd0) begin
      n_err++; $display("FAIL first_sample: valid=%0b snd=%0d ch=%0d want 1/30/0", bus.snd_valid, bus.snd, bus.snd_ch); end
    @(negedge clk);
    n_vec++; if (bus.snd_valid !== 1'b0 || bus.snd !== 12'sd30) begin
      n_err++; $display("FAIL hold: valid=%0b snd=%0d want 0/30", bus.snd_valid, bus.snd); end
    evq.delete();
    // 0x7 -> 93 (idx16), 0xF -> -43 (idx24), 0x0 at idx24 -> -43+19 = -24
    drive(1, 1, 0, 4'h7); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== es[0] || ch !== 2'd0) begin n_err++; $display("FAIL step_7: ok=%0b snd=%0d ch=%0d want %0d/0", ok, s, ch, es[0]); end
    drive(1, 1, 0, 4'hF); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== es[1] || ch !== 2'd0) begin n_err++; $display("FAIL step_F: ok=%0b snd=%0d ch=%0d want %0d/0", ok, s, ch, es[1]); end
    drive(1, 1, 0, 4'h0); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== es[2] || ch !== 2'd0) begin n_err++; $display("FAIL idx24: ok=%0b snd=%0d ch=%0d want %0d/0", ok, s, ch, es[2]); end
  endtask

  task automatic test_saturation();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    for (int n = 0; n < 10; n++) begin
      drive(1, 1, (n == 0), 4'h7); idle(); get_ev(s, ch, ok);
      if (n == 4) begin
        n_vec++; if (!ok || s !== 12'sd1153) begin n_err++; $display("FAIL climb: ok=%0b snd=%0d want 1153", ok, s); end
      end
    end
    n_vec++; if (!ok || s !== 12'sd2047) begin n_err++; $display("FAIL sat_hi: ok=%0b snd=%0d want 2047", ok, s); end
    drive(1, 1, 0, 4'hF); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== -12'sd863) begin n_err++; $display("FAIL idx48: ok=%0b snd=%0d want -863", ok, s); end
    for (int n = 0; n < 9; n++) begin drive(1, 1, 0, 4'hF); idle(); get_ev(s, ch, ok); end
    n_vec++; if (!ok || s !== -12'sd2048) begin n_err++; $display("FAIL sat_lo: ok=%0b snd=%0d want -2048", ok, s); end
    for (int n = 0; n < 48; n++) begin drive(1, 1, 0, 4'h0); idle(); get_ev(s, ch, ok); end
    n_vec++; if (!ok || s !== 12'sd41) begin n_err++; $display("FAIL zero_walk: ok=%0b snd=%0d want 41", ok, s); end
    for (int n = 0; n < 10; n++) begin drive(1, 1, 0, 4'h0); idle(); get_ev(s, ch, ok); end
    n_vec++; if (!ok || s !== 12'sd61) begin n_err++; $display("FAIL idx_floor: ok=%0b snd=%0d want 61", ok, s); end
  endtask

  task automatic test_back_to_back();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    drive(1, 1, 1, 4'h7); drive(1, 1, 0, 4'h7); idle();
    get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== 12'sd30 || ch !== 2'd0) begin n_err++; $display("FAIL bypass_a: ok=%0b snd=%0d ch=%0d want 30/0", ok, s, ch); end
    get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== 12'sd93 || ch !== 2'd0) begin n_err++; $display("FAIL bypass_b: ok=%0b snd=%0d ch=%0d want 93/0", ok, s, ch); end
  endtask

  task automatic test_interleave();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    logic signed [11:0] e1 [4] = '{12'sd30, 12'sd2, -12'sd30, 12'sd18};
    logic signed [11:0] e2 [3] = '{12'sd38, -12'sd34, 12'sd20};
    rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
    evq.delete();
    drive(0, 1, 1, 4'h7); drive(0, 1, 1, 4'h0); drive(0, 1, 1, 4'hF); drive(0, 1, 1, 4'h4); idle();
    for (int i = 0; i < 4; i++) begin
      get_ev(s, ch, ok);
      n_vec++; if (!ok || s !== e1[i] || ch !== 2'(i)) begin
        n_err++; $display("FAIL interleave_%0d: ok=%0b snd=%0d ch=%0d want %0d/%0d", i, ok, s, ch, e1[i], i); end
    end
    n_vec++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL wrap_slot: got %0d want 0", bus.slot); end
    drive(0, 1, 0, 4'h0); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== 12'sd34 || ch !== 2'd0) begin n_err++; $display("FAIL ch0_r2: ok=%0b snd=%0d ch=%0d want 34/0", ok, s, ch); end
    drive(0, 1, 0, 4'h1); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== 12'sd8 || ch !== 2'd1) begin n_err++; $display("FAIL ch1_r2: ok=%0b snd=%0d ch=%0d want 8/1", ok, s, ch); end
    n_vec++; if (bus.slot !== 2'd2) begin n_err++; $display("FAIL slot_pre_sync: got %0d want 2", bus.slot); end
    drive(1, 1, 0, 4'h0); idle(); get_ev(s, ch, ok);
    n_vec++; if (!ok || s !== 12'sd37 || ch !== 2'd0) begin n_err++; $display("FAIL sync_ch0: ok=%0b snd=%0d ch=%0d want 37/0", ok, s, ch); end
    n_vec++; if (bus.slot !== 2'd1) begin n_err++; $display("FAIL slot_post_sync: got %0d want 1", bus.slot); end
    drive(0, 1, 0, 4'h7); drive(0, 1, 0, 4'h8); drive(0, 1, 0, 4'h0); idle();
    for (int i = 0; i < 3; i++) begin
      get_ev(s, ch, ok);
      n_vec++; if (!ok || s !== e2[i] || ch !== 2'(i + 1)) begin
        n_err++; $display("FAIL independent_%0d: ok=%0b snd=%0d ch=%0d want %0d/%0d", i, ok, s, ch, e2[i], i + 1); end
    end
  endtask

  task automatic test_en_off();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    logic signed [11:0] ee [6] = '{12'sd40, 12'sd0, -12'sd31, 12'sd22, 12'sd0, 12'sd30};
    drive(0, 1, 0, 4'h0); drive(0, 0, 0, 4'h7); drive(0, 1, 0, 4'h0); drive(0, 1, 0, 4'h0);
    drive(0, 0, 1, 4'h7); drive(0, 1, 0, 4'h7); idle();
    for (int i = 0; i < 6; i++) begin
      get_ev(s, ch, ok);
      n_vec++; if (!ok || s !== ee[i] || ch !== 2'(i % 4)) begin
        n_err++; $display("FAIL en_off_%0d: ok=%0b snd=%0d ch=%0d want %0d/%0d", i, ok, s, ch, ee[i], i % 4); end
    end
  endtask

  task automatic test_reset_flush();
    logic signed [11:0] s; logic [1:0] ch; bit ok;
    drive(0, 1, 0, 4'h7);
    @(negedge clk); rst = 1'b1; bus.cen = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; bus.cen = 1'b0; bus.en = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (evq.size() !== 0) begin n_err++; $display("FAIL flush_valid: %0d pulses want 0", evq.size()); end
    n_vec++; if (bus.slot !== 2'd0 || bus.snd !== 12'sd0 || bus.snd_ch !== 2'd0 || bus.snd_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_outputs: slot=%0d snd=%0d ch=%0d valid=%0b want 0/0/0/0", bus.slot, bus.snd, bus.snd_ch, bus.snd_valid); end
    evq.delete();
    drive(0, 1, 0, 4'h0); drive(0, 1, 0, 4'h0); drive(0, 1, 0, 4'h0); drive(0, 1, 0, 4'h0); idle();
    for (int i = 0; i < 4; i++) begin
      get_ev(s, ch, ok);
      n_vec++; if (!ok || s !== 12'sd2 || ch !== 2'(i)) begin
        n_err++; $display("FAIL cleared_state_%0d: ok=%0b snd=%0d ch=%0d want 2/%0d", i, ok, s, ch, i); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_interleave();
    test_en_off();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
